// File: rtl/bcd_counter_scan.sv
// Two-digit BCD up/down counter (00-99) with prescaled stepping, synchronous load
// and a two-state digit scanner driving a common-anode display through a BCD decoder.
module bcd_counter_scan #(
  parameter int CNT_DIV  = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic [1:0] dig_sel,
  output logic [7:0] count,
  output logic       tc
);

  localparam int CW = $clog2(CNT_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  typedef enum logic {S_UNITS, S_TENS} scan_state_t;

  logic [CW-1:0] r_step_cnt;
  logic [SW-1:0] r_scan_cnt;
  logic [7:0]    r_count;
  logic          r_tc;
  logic [1:0]    r_dig_sel;
  logic [3:0]    r_nibble;
  scan_state_t   r_state;

  logic          w_step;
  logic [7:0]    w_step_count;
  logic          w_wrap;
  logic [7:0]    w_load_count;
  logic          w_scan_wrap;
  scan_state_t   w_state_next;
  logic [SW-1:0] w_scan_cnt_next;

  assign w_step = en && (r_step_cnt == CW'(CNT_DIV - 1));

  // Out-of-range load nibbles are forced to 0 so count stays valid BCD.
  assign w_load_count[7:4] = (load_val[7:4] > 4'd9) ? 4'd0 : load_val[7:4];
  assign w_load_count[3:0] = (load_val[3:0] > 4'd9) ? 4'd0 : load_val[3:0];

  always_comb begin
    w_step_count = r_count;
    w_wrap       = 1'b0;
    if (up) begin
      if (r_count[3:0] == 4'd9) begin
        if (r_count[7:4] == 4'd9) begin
          w_step_count = 8'h00;
          w_wrap       = 1'b1;
        end else begin
          w_step_count = {r_count[7:4] + 4'd1, 4'd0};
        end
      end else begin
        w_step_count = {r_count[7:4], r_count[3:0] + 4'd1};
      end
    end else begin
      if (r_count[3:0] == 4'd0) begin
        if (r_count[7:4] == 4'd0) begin
          w_step_count = 8'h99;
          w_wrap       = 1'b1;
        end else begin
          w_step_count = {r_count[7:4] - 4'd1, 4'd9};
        end
      end else begin
        w_step_count = {r_count[7:4], r_count[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_cnt <= '0;
      r_count    <= 8'h00;
      r_tc       <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (load) begin
        r_count    <= w_load_count;
        r_step_cnt <= '0;
      end else if (en) begin
        if (w_step) begin
          r_step_cnt <= '0;
          r_count    <= w_step_count;
          r_tc       <= w_wrap;
        end else begin
          r_step_cnt <= r_step_cnt + CW'(1);
        end
      end
    end
  end

  // Scan FSM: the slot timer runs freely, independent of en.
  always_comb begin
    w_state_next    = r_state;
    w_scan_wrap     = (r_scan_cnt == SW'(SCAN_DIV - 1));
    w_scan_cnt_next = r_scan_cnt + SW'(1);
    if (w_scan_wrap) begin
      w_scan_cnt_next = '0;
      case (r_state)
        S_UNITS: w_state_next = S_TENS;
        S_TENS:  w_state_next = S_UNITS;
        default: w_state_next = S_UNITS;
      endcase
    end
  end

  // Outputs follow the next state so dig_sel and nibble flip on the toggle edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_UNITS;
      r_scan_cnt <= '0;
      r_dig_sel  <= 2'b10;
      r_nibble   <= 4'b0000;
    end else begin
      r_state    <= w_state_next;
      r_scan_cnt <= w_scan_cnt_next;
      if (w_state_next == S_TENS) begin
        r_dig_sel <= 2'b01;
        r_nibble  <= r_count[7:4];
      end else begin
        r_dig_sel <= 2'b10;
        r_nibble  <= r_count[3:0];
      end
    end
  end

  assign {W, X, Y, Z} = r_nibble;
  assign dig_sel      = r_dig_sel;
  assign count        = r_count;
  assign tc           = r_tc;

endmodule

// File: tb/tb_bcd_counter_scan.sv
// Directed bench for bcd_counter_scan with CNT_DIV = 4 and SCAN_DIV = 3;
// expected values are hand-computed from the step/scan timing.
module tb_bcd_counter_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic       W, X, Y, Z;
  logic [1:0] dig_sel;
  logic [7:0] count;
  logic       tc;

  int n_checks = 0;
  int n_errors = 0;

  bcd_counter_scan #(.CNT_DIV(4), .SCAN_DIV(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .W        (W),
    .X        (X),
    .Y        (Y),
    .Z        (Z),
    .dig_sel  (dig_sel),
    .count    (count),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end else begin
      $display("check %s: %h ok", tag, obs);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load     = 1'b1;
    load_val = v;
    tick(1);
    load     = 1'b0;
  endtask

  initial begin
    logic [1:0] prev_sel;
    logic [1:0] exp_sel;
    logic [3:0] exp_nib;
    int         guard;

    // Power-on reset
    tick(3);
    check("rst_count", count, 8'h00);
    check("rst_sel", {6'd0, dig_sel}, 8'h02);
    check("rst_nib", {4'd0, W, X, Y, Z}, 8'h00);
    check("rst_tc", {7'd0, tc}, 8'h00);
    rst_n = 1'b1;
    tick(1);

    // Scan with count held at 52
    do_load(8'h52);
    check("scan_load", count, 8'h52);
    tick(2);
    prev_sel = dig_sel;
    guard    = 0;
    tick(1);
    while (dig_sel == prev_sel && guard < 10) begin
      tick(1);
      guard++;
    end
    check("scan_align", {7'd0, guard >= 10}, 8'h00);
    exp_sel = dig_sel;
    for (int s = 0; s < 4; s++) begin
      exp_nib = (exp_sel == 2'b10) ? 4'h2 : 4'h5;
      for (int c = 0; c < 3; c++) begin
        check("scan_sel", {6'd0, dig_sel}, {6'd0, exp_sel});
        check("scan_nib", {4'd0, W, X, Y, Z}, {4'd0, exp_nib});
        check("scan_not_both", {7'd0, dig_sel == 2'b00}, 8'h00);
        tick(1);
      end
      exp_sel = ~exp_sel;
    end

    // Asynchronous reset mid-count at 47
    do_load(8'h47);
    en = 1'b1;
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count, 8'h00);
    check("arst_sel", {6'd0, dig_sel}, 8'h02);
    check("arst_nib", {4'd0, W, X, Y, Z}, 8'h00);
    check("arst_tc", {7'd0, tc}, 8'h00);
    tick(1);
    rst_n = 1'b1;

    // Up wrap 98 -> 99 -> 00
    en = 1'b1;
    up = 1'b1;
    do_load(8'h98);
    tick(3);
    check("up_hold98", count, 8'h98);
    tick(1);
    check("up_99", count, 8'h99);
    check("up_99_tc", {7'd0, tc}, 8'h00);
    tick(3);
    check("up_hold99", count, 8'h99);
    tick(1);
    check("up_wrap", count, 8'h00);
    check("up_wrap_tc", {7'd0, tc}, 8'h01);
    tick(1);
    check("up_tc_end", {7'd0, tc}, 8'h00);
    do_load(8'h09);
    tick(4);
    check("up_carry", count, 8'h10);

    // Down wrap 01 -> 00 -> 99
    up = 1'b0;
    do_load(8'h01);
    tick(4);
    check("dn_00", count, 8'h00);
    check("dn_00_tc", {7'd0, tc}, 8'h00);
    tick(4);
    check("dn_wrap", count, 8'h99);
    check("dn_wrap_tc", {7'd0, tc}, 8'h01);
    tick(1);
    check("dn_tc_end", {7'd0, tc}, 8'h00);
    do_load(8'h10);
    tick(4);
    check("dn_borrow", count, 8'h09);

    // Load on a step cycle wins and clamps
    up = 1'b1;
    do_load(8'h99);
    tick(3);
    do_load(8'h3F);
    check("ld_prio", count, 8'h30);
    check("ld_prio_tc", {7'd0, tc}, 8'h00);
    tick(3);
    check("ld_next_hold", count, 8'h30);
    tick(1);
    check("ld_next_step", count, 8'h31);
    do_load(8'hA7);
    check("ld_clamp", count, 8'h07);

    // Enable hold mid-prescaler
    do_load(8'h50);
    tick(2);
    en = 1'b0;
    tick(10);
    check("en_frozen", count, 8'h50);
    en = 1'b1;
    tick(1);
    check("en_remain", count, 8'h50);
    tick(1);
    check("en_step", count, 8'h51);

    // Load with enable low
    en = 1'b0;
    do_load(8'h64);
    check("ld_no_en", count, 8'h64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
